pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline stall/flush scheduler for the 5-stage core. Takes decoded ID-stage operand info (rs1/rs2,
//  data_dependency_check, CSR flag), in-flight EX/MEM writer info, EX branch/jump redirect and data
//  memory busy. Drives per-stage stall/bubble/flush controls. Sequences load-use bubbles, CSR
//  serialisation and memory-wait freezes, and keeps stall/flush performance counters.
// PARAMETERS
//  REG_W       5      register index width
//  WB_SRC_W    3      width of wb_src field
//  WB_DATAMEM  3'd1   wb_src code for a load (value comes from data memory)
//  CNT_W       32     width of performance counters (saturating)
// PORTS
//  clk            in   1         core clock
//  rst            in   1         synchronous active-high reset
//  id_valid       in   1         ID stage holds a valid instruction
//  id_rs1/id_rs2  in   REG_W     ID source registers
//  id_dep_chk     in   2         [1]=rs1 read from regfile, [0]=rs2 read from regfile
//  id_is_csr      in   1         ID instruction is SYSTEM/CSR
//  ex_valid/ex_wen/ex_rd/ex_wb_src   in 1/1/REG_W/WB_SRC_W   EX-stage writer info
//  mem_valid/mem_wen                 in 1/1                  MEM-stage writer info
//  ex_redirect    in   1         branch taken or jump resolved in EX
//  dmem_busy      in   1         data memory access not complete this cycle
//  pc_stall       out  1         hold PC
//  if_id_stall    out  1         hold IF/ID register
//  if_id_flush    out  1         clear IF/ID to NOP
//  id_ex_stall    out  1         hold ID/EX register
//  id_ex_bubble   out  1         load NOP into ID/EX
//  ex_mem_stall   out  1         hold EX/MEM register
//  mem_wb_bubble  out  1         load NOP into MEM/WB
//  state          out  2         FSM state (debug)
//  stall_cycles   out  CNT_W     count of cycles with pc_stall=1
//  flush_count    out  CNT_W     count of cycles with if_id_flush=1
// BEHAVIOUR
//  - Reset: one clock, synchronous, active-high. While rst=1 all control outputs are 0. Registered
//    values clear to state=RUN, stall_cycles=0, flush_count=0.
//  - Control outputs are combinational (Mealy) from state and current inputs. No registered latency.
//  - Conditions:
//      lu  = id_valid & ex_valid & ex_wen & ex_wb_src==WB_DATAMEM & ex_rd!=0 &
//            ((id_dep_chk[1] & id_rs1==ex_rd) | (id_dep_chk[0] & id_rs2==ex_rd))
//      csr = id_valid & id_is_csr & ((ex_valid & ex_wen) | (mem_valid & mem_wen))
//  - Priority, highest first. Exactly one applies per cycle:
//    1 dmem_busy (freeze): pc_stall, if_id_stall, id_ex_stall and ex_mem_stall are 1;
//      mem_wb_bubble=1. The EX stage is held, so ex_redirect and lu persist and are acted on after release.
//    2 ex_redirect (flush): if_id_flush=1, id_ex_bubble=1, no stalls. This cancels any lu/csr stall.
//    3 lu (load-use): pc_stall=1, if_id_stall=1, id_ex_bubble=1 for one cycle.
//    4 csr (serialise): pc_stall=1, if_id_stall=1, id_ex_bubble=1.
//    5 none: all outputs 0.
//  - FSM states: RUN=0, LU_STALL=1, CSR_DRAIN=2, MEM_WAIT=3.
//    Next state from the priority that applied: 1->MEM_WAIT, 2->RUN, 3->LU_STALL, 4->CSR_DRAIN, 5->RUN.
//    LU_STALL lasts 1 cycle: EX holds the bubble, so lu is false there.
//    CSR_DRAIN persists while csr=1. MEM_WAIT persists while dmem_busy=1.
//  - Counters increment at the clock edge when the matching output is 1. They saturate at all-ones
//    and do not wrap.
//  - ex_rd==0 never causes a stall. A dependency is ignored when its id_dep_chk bit is 0 (PC/imm/zero operand).
//  - rst asserted in any state (including MEM_WAIT mid-freeze): the next cycle is RUN with counters 0.
//    No pending stall survives the reset.
// TESTING
//  1 EX: ex_rd=5, ex_wen=1, ex_wb_src=WB_DATAMEM. ID: id_rs1=5, id_dep_chk=2'b10
//    -> pc_stall, if_id_stall and id_ex_bubble are 1 for 1 cycle; state=LU_STALL, then RUN; stall_cycles=1.
//  2 Same as 1 but ex_rd=0, or id_dep_chk=2'b00, or ex_wb_src=result
//    -> all outputs 0; state stays RUN.
//  3 dmem_busy=1 for 3 cycles while the load-use of test 1 is present
//    -> 3 freeze cycles (mem_wb_bubble=1, id_ex_bubble=0), then 1 load-use bubble; stall_cycles=4.
//  4 ex_redirect=1 together with a load-use
//    -> if_id_flush=1, id_ex_bubble=1, pc_stall=0; flush_count=1; next state RUN.
//  5 ID CSR, ex_wen=1 and mem_wen=1, pipeline drains one stage per cycle
//    -> stall 2 cycles in CSR_DRAIN, released once no writer remains in EX/MEM.
//  6 rst pulsed in cycle 2 of a MEM_WAIT
//    -> outputs 0 during reset; afterwards state=RUN, stall_cycles=0, flush_count=0.
//  7 Force stall_cycles to all-ones and hold a stall
//    -> stall_cycles stays at all-ones.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage core: Mealy stage controls from hazard priority,
// a debug FSM tracking which hazard applied last cycle, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int WB_SRC_W = 3,
  parameter logic [WB_SRC_W-1:0] WB_DATAMEM = 1,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic [1:0]          id_dep_chk,
  input  logic                id_is_csr,
  input  logic                ex_valid,
  input  logic                ex_wen,
  input  logic [REG_W-1:0]    ex_rd,
  input  logic [WB_SRC_W-1:0] ex_wb_src,
  input  logic                mem_valid,
  input  logic                mem_wen,
  input  logic                ex_redirect,
  input  logic                dmem_busy,
  output logic                pc_stall,
  output logic                if_id_stall,
  output logic                if_id_flush,
  output logic                id_ex_stall,
  output logic                id_ex_bubble,
  output logic                ex_mem_stall,
  output logic                mem_wb_bubble,
  output logic [1:0]          state,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic [CNT_W-1:0]    flush_count
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_STALL  = 2'd1,
    CSR_DRAIN = 2'd2,
    MEM_WAIT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t cur_state, nxt_state;
  logic   lu, csr_hz, rs1_hit, rs2_hit;

  assign rs1_hit = id_dep_chk[1] && (id_rs1 == ex_rd);
  assign rs2_hit = id_dep_chk[0] && (id_rs2 == ex_rd);
  assign lu      = id_valid && ex_valid && ex_wen && (ex_wb_src == WB_DATAMEM) &&
                   (ex_rd != '0) && (rs1_hit || rs2_hit);
  assign csr_hz  = id_valid && id_is_csr && ((ex_valid && ex_wen) || (mem_valid && mem_wen));

  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_bubble = 1'b0;
    nxt_state     = RUN;
    if (rst) begin
      nxt_state = RUN;
    end else if (dmem_busy) begin
      // whole front end frozen; EX contents (and any redirect/lu) survive the wait
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_stall   = 1'b1;
      ex_mem_stall  = 1'b1;
      mem_wb_bubble = 1'b1;
      nxt_state     = MEM_WAIT;
    end else if (ex_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      nxt_state    = RUN;
    end else if (lu) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
      nxt_state    = LU_STALL;
    end else if (csr_hz) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
      nxt_state    = CSR_DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state    <= RUN;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      cur_state <= nxt_state;
      if (pc_stall && (stall_cycles != CNT_MAX))
        stall_cycles <= stall_cycles + CNT_ONE;
      if (if_id_flush && (flush_count != CNT_MAX))
        flush_count <= flush_count + CNT_ONE;
    end
  end

  assign state = cur_state;

endmodule
